// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive front end.
// Holds the receiver state encoding, the oversampling constants and the
// baud divider calculation used by uart_rx_fifo_writer and uart_baud_tick.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  // Sample ticks per bit and the tick on which the start bit is re-checked.
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  // Clocks per sample tick, truncated (27 for 50 MHz / 115200 baud).
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_writer_if.sv
// uart_rx_fifo_writer_if: write side of the byte FIFO as seen by the receiver.
// Handshake: fifo_wr_ena is a one-cycle write strobe and fifo_wr_dat is valid
// while it is high. There is no ready; the writer only strobes when
// fifo_full=0 and fifo_usedw is below the refusal margin in the cycle the
// decision is made, so the FIFO must accept every strobe it sees.
interface uart_rx_fifo_writer_if;

  logic [10:0] fifo_usedw;
  logic        fifo_full;
  logic        fifo_wr_ena;
  logic [7:0]  fifo_wr_dat;

  // Receiver side: reads fill level, drives the write strobe and data.
  modport master (
    input  fifo_usedw,
    input  fifo_full,
    output fifo_wr_ena,
    output fifo_wr_dat
  );

  // FIFO side: accepts writes and reports its fill level.
  modport slave (
    output fifo_usedw,
    output fifo_full,
    input  fifo_wr_ena,
    input  fifo_wr_dat
  );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing one sample tick every DIV
// clocks. clear_i holds the count at zero so the first tick after release
// lands exactly DIV clocks later.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Next count: wrap at DIV-1, forced to zero while cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider count register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// uart_rx_fifo_writer: 8N1 UART receiver that writes each good byte into the
// 2048-entry byte FIFO, refuses writes near full (sticky overflow) and pulses
// frame_err on a bad stop bit.
// Build option: define UART_PARITY_EN for 8E1 frames; a PARITY state is then
// inserted between DATA and STOP and a parity failure also pulses frame_err.
module uart_rx_fifo_writer
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 2048,
  parameter int FULL_MARGIN = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx,
  uart_rx_fifo_writer_if.master        fifo,
  output logic                         frame_err,
  output logic                         overflow,
  output uart_state_e                  state_dbg
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int SW    = $clog2(OVERSAMPLE) + 1;
  localparam int LIMIT = FIFO_DEPTH - FULL_MARGIN;
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMPLE_MID  = SW'(MID_SAMPLE - 1);

  // Line synchroniser and edge history, all idling high.
  logic rx_meta_q;
  logic rxs_q;
  logic rxs_prev_q;

  uart_state_e   state_q, state_d;
  logic [SW-1:0] sample_q, sample_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          wr_ena_q, wr_ena_d;
  logic [7:0]    wr_dat_q, wr_dat_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
`ifdef UART_PARITY_EN
  logic          par_q, par_d;
`endif

  logic div_clr;
  logic tick;
  logic room;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .clear_i (div_clr),
    .tick_o  (tick)
  );

  // Room is judged from the fill level seen in the stop-sample cycle itself.
  assign room = !fifo.fifo_full && (int'({1'b0, fifo.fifo_usedw}) < LIMIT);

  assign fifo.fifo_wr_ena = wr_ena_q;
  assign fifo.fifo_wr_dat = wr_dat_q;
  assign frame_err        = ferr_q;
  assign overflow         = ovf_q;
  assign state_dbg        = state_q;

  // Next-state and registered-output decode for the receive FSM.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    wr_ena_d = 1'b0;
    wr_dat_d = wr_dat_q;
    ferr_d   = 1'b0;
    ovf_d    = ovf_q;
    div_clr  = 1'b0;
`ifdef UART_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      IDLE: begin
        // Divider held at zero so START begins a fresh tick period.
        div_clr  = 1'b1;
        sample_d = '0;
        bit_d    = '0;
        if (rxs_prev_q && !rxs_q) begin
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          if (sample_q == SAMPLE_MID) begin
            sample_d = '0;
            bit_d    = '0;
            // A line that is high again mid start bit was only a glitch.
            state_d  = rxs_q ? IDLE : DATA;
          end else begin
            sample_d = sample_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (sample_q == SAMPLE_LAST) begin
            sample_d = '0;
            shift_d  = {rxs_q, shift_q[7:1]};
            bit_d    = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            sample_d = sample_q + SW'(1);
          end
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (sample_q == SAMPLE_LAST) begin
            sample_d = '0;
            par_d    = rxs_q;
            state_d  = STOP;
          end else begin
            sample_d = sample_q + SW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (sample_q == SAMPLE_LAST) begin
            sample_d = '0;
            if (!rxs_q) begin
              // Line still low at the stop bit: framing error or break.
              ferr_d  = 1'b1;
              state_d = BREAK;
            end else begin
              state_d = IDLE;
`ifdef UART_PARITY_EN
              if (^{shift_q, par_q}) begin
                ferr_d = 1'b1;
              end else if (room) begin
                wr_ena_d = 1'b1;
                wr_dat_d = shift_q;
              end else begin
                ovf_d = 1'b1;
              end
`else
              if (room) begin
                wr_ena_d = 1'b1;
                wr_dat_d = shift_q;
              end else begin
                ovf_d = 1'b1;
              end
`endif
            end
          end else begin
            sample_d = sample_q + SW'(1);
          end
        end
      end

      BREAK: begin
        // Edges are ignored until the line has returned to idle.
        if (rxs_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      sample_q   <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ena_q   <= 1'b0;
      wr_dat_q   <= '0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef UART_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      sample_q   <= sample_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ena_q   <= wr_ena_d;
      wr_dat_q   <= wr_dat_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
`ifdef UART_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// tb_uart_rx_fifo_writer: directed bench for uart_rx_fifo_writer at the
// default rates (DIV=27, 432 clk per bit). Define UART_PARITY_EN to build and
// exercise the 8E1 variant.
module tb_uart_rx_fifo_writer;
  import uart_pkg::*;

  localparam int BIT_CLK = 432;
`ifdef UART_PARITY_EN
  localparam int LAT_NOM = 4107 + BIT_CLK;
`else
  localparam int LAT_NOM = 4107;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        rx    = 1'b1;
  logic        frame_err;
  logic        overflow;
  uart_state_e state_dbg;

  uart_rx_fifo_writer_if fifo_bus ();

  uart_rx_fifo_writer dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .fifo      (fifo_bus),
    .frame_err (frame_err),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];
  int         wr_cyc_q[$];
  int         ferr_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  // Monitor: capture every write strobe and frame_err pulse mid-cycle.
  always @(negedge clk) begin
    if (fifo_bus.fifo_wr_ena === 1'b1) begin
      act_q.push_back(fifo_bus.fifo_wr_dat);
      wr_cyc_q.push_back(cyc);
    end
    if (frame_err === 1'b1) ferr_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Sends start, 8 data bits LSB first, correct even parity when built with
  // parity, then the given stop bit; rx is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef UART_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    n_cmp++; if (fifo_bus.fifo_wr_ena !== 1'b0) begin n_err++; $display("FAIL reset_wr_ena: got %b expected 0", fifo_bus.fifo_wr_ena); end
    n_cmp++; if (fifo_bus.fifo_wr_dat !== 8'h00) begin n_err++; $display("FAIL reset_wr_dat: got %h expected 00", fifo_bus.fifo_wr_dat); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    reset = 1'b1;
    idle(BIT_CLK);
  endtask

  task automatic test_basic();
    int base, fbase, t0, lat;
    logic [7:0] got;
    base  = act_q.size();
    fbase = ferr_cnt;
    t0    = cyc;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(BIT_CLK);
    got = (act_q.size() > base) ? act_q[base] : 8'hxx;
    lat = (wr_cyc_q.size() > base) ? (wr_cyc_q[base] - t0) : -1;
    n_cmp++; if (act_q.size() - base !== 1) begin n_err++; $display("FAIL basic_write_count: got %0d expected 1", act_q.size() - base); end
    n_cmp++; if (got !== exp_q[0]) begin n_err++; $display("FAIL basic_data: got %h expected %h", got, exp_q[0]); end
    n_cmp++; if (lat < LAT_NOM - 3 || lat > LAT_NOM + 3) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d+-3", lat, LAT_NOM); end
    n_cmp++; if (ferr_cnt - fbase !== 0) begin n_err++; $display("FAIL basic_frame_err: got %0d pulses expected 0", ferr_cnt - fbase); end
    n_cmp++; if (fifo_bus.fifo_wr_dat !== 8'h55) begin n_err++; $display("FAIL basic_dat_hold: got %h expected 55", fifo_bus.fifo_wr_dat); end
    exp_q.delete();
  endtask

  task automatic test_glitch();
    int base;
    logic [7:0] got;
    base = act_q.size();
    rx = 1'b0;
    idle(100);
    rx = 1'b1;
    idle(300);
    n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL glitch_state: got %0d expected %0d", state_dbg, IDLE); end
    n_cmp++; if (act_q.size() - base !== 0) begin n_err++; $display("FAIL glitch_no_write: got %0d writes expected 0", act_q.size() - base); end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    idle(BIT_CLK);
    got = (act_q.size() > base) ? act_q[base] : 8'hxx;
    n_cmp++; if (act_q.size() - base !== 1) begin n_err++; $display("FAIL glitch_follow_count: got %0d expected 1", act_q.size() - base); end
    n_cmp++; if (got !== exp_q[0]) begin n_err++; $display("FAIL glitch_follow_data: got %h expected %h", got, exp_q[0]); end
    exp_q.delete();
  endtask

  task automatic test_break();
    int base, fbase;
    logic [7:0] got;
    base  = act_q.size();
    fbase = ferr_cnt;
    send_frame(8'hA3, 1'b0);
    idle(2000 - BIT_CLK);
    n_cmp++; if (state_dbg !== BREAK) begin n_err++; $display("FAIL break_state: got %0d expected %0d", state_dbg, BREAK); end
    n_cmp++; if (ferr_cnt - fbase !== 1) begin n_err++; $display("FAIL break_frame_err: got %0d pulses expected 1", ferr_cnt - fbase); end
    n_cmp++; if (act_q.size() - base !== 0) begin n_err++; $display("FAIL break_no_write: got %0d writes expected 0", act_q.size() - base); end
    rx = 1'b1;
    idle(BIT_CLK);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(BIT_CLK);
    got = (act_q.size() > base) ? act_q[base] : 8'hxx;
    n_cmp++; if (act_q.size() - base !== 1) begin n_err++; $display("FAIL break_follow_count: got %0d expected 1", act_q.size() - base); end
    n_cmp++; if (got !== exp_q[0]) begin n_err++; $display("FAIL break_follow_data: got %h expected %h", got, exp_q[0]); end
    n_cmp++; if (ferr_cnt - fbase !== 1) begin n_err++; $display("FAIL break_follow_ferr: got %0d pulses expected 1", ferr_cnt - fbase); end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    int base;
    logic [7:0] got;
    // Highest level that still has room: 2043 < 2048-4.
    base = act_q.size();
    fifo_bus.fifo_usedw = 11'd2043;
    send_frame(8'h5E, 1'b1);
    idle(BIT_CLK);
    got = (act_q.size() > base) ? act_q[base] : 8'hxx;
    n_cmp++; if (got !== 8'h5E) begin n_err++; $display("FAIL ovf_edge_write: got %h expected 5e", got); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_edge_flag: got %b expected 0", overflow); end
    // First refused level.
    base = act_q.size();
    fifo_bus.fifo_usedw = 11'd2044;
    send_frame(8'h12, 1'b1);
    idle(BIT_CLK);
    n_cmp++; if (act_q.size() - base !== 0) begin n_err++; $display("FAIL ovf_drop: got %0d writes expected 0", act_q.size() - base); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    // Full flag alone refuses too.
    fifo_bus.fifo_usedw = 11'd0;
    fifo_bus.fifo_full  = 1'b1;
    send_frame(8'h77, 1'b1);
    idle(BIT_CLK);
    n_cmp++; if (act_q.size() - base !== 0) begin n_err++; $display("FAIL ovf_full_drop: got %0d writes expected 0", act_q.size() - base); end
    // Room again: byte written, overflow stays sticky.
    fifo_bus.fifo_full  = 1'b0;
    fifo_bus.fifo_usedw = 11'd100;
    send_frame(8'h34, 1'b1);
    idle(BIT_CLK);
    got = (act_q.size() > base) ? act_q[base] : 8'hxx;
    n_cmp++; if (got !== 8'h34) begin n_err++; $display("FAIL ovf_recover_write: got %h expected 34", got); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    logic [7:0] partial;
    logic [7:0] got;
    partial = 8'h5A;
    base = act_q.size();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    rx = partial[4];
    idle(BIT_CLK / 2);
    reset = 1'b0;
    idle(1);
    n_cmp++; if (fifo_bus.fifo_wr_ena !== 1'b0) begin n_err++; $display("FAIL midrst_wr_ena: got %b expected 0", fifo_bus.fifo_wr_ena); end
    n_cmp++; if (fifo_bus.fifo_wr_dat !== 8'h00) begin n_err++; $display("FAIL midrst_wr_dat: got %h expected 00", fifo_bus.fifo_wr_dat); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
    n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL midrst_state: got %0d expected %0d", state_dbg, IDLE); end
    idle(1);
    reset = 1'b1;
    rx = 1'b1;
    idle(12 * BIT_CLK);
    n_cmp++; if (act_q.size() - base !== 0) begin n_err++; $display("FAIL midrst_no_partial: got %0d writes expected 0", act_q.size() - base); end
    send_frame(8'h81, 1'b1);
    idle(BIT_CLK);
    got = (act_q.size() > base) ? act_q[base] : 8'hxx;
    n_cmp++; if (got !== 8'h81) begin n_err++; $display("FAIL midrst_follow_data: got %h expected 81", got); end
    n_cmp++; if (act_q.size() - base !== 1) begin n_err++; $display("FAIL midrst_follow_count: got %0d expected 1", act_q.size() - base); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    int base, fbase;
    logic [7:0] got;
    base  = act_q.size();
    fbase = ferr_cnt;
    // 0x07 has three ones: parity bit must be 1 for even parity.
    send_frame_par(8'h07, 1'b0);
    idle(BIT_CLK);
    n_cmp++; if (ferr_cnt - fbase !== 1) begin n_err++; $display("FAIL parity_bad_ferr: got %0d pulses expected 1", ferr_cnt - fbase); end
    n_cmp++; if (act_q.size() - base !== 0) begin n_err++; $display("FAIL parity_bad_drop: got %0d writes expected 0", act_q.size() - base); end
    send_frame_par(8'h07, 1'b1);
    idle(BIT_CLK);
    got = (act_q.size() > base) ? act_q[base] : 8'hxx;
    n_cmp++; if (got !== 8'h07) begin n_err++; $display("FAIL parity_good_data: got %h expected 07", got); end
    n_cmp++; if (ferr_cnt - fbase !== 1) begin n_err++; $display("FAIL parity_good_ferr: got %0d pulses expected 1", ferr_cnt - fbase); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    fifo_bus.fifo_usedw = 11'd0;
    fifo_bus.fifo_full  = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overflow();
    test_reset_mid_frame();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
